router_fsm_nch: RTL and testbench

Parametrised packet-router control FSM for a 1xNUM_CH router. It decodes the header address and sequences header/payload/parity loading into the selected output FIFO. It stalls on FIFO-full and waits for a busy destination FIFO to drain, with a bounded wait. It also drops packets addressed to nonexistent channels, and soft resets apply only to the channel in use. It sits between the input register block and the NUM_CH output FIFOs.

---
 rtl/router_fsm_nch_if.sv | 36 +++
 rtl/router_fsm_nch.sv | 87 ++++++++
 tb/tb_router_fsm_nch.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: handshake/bus bundle between the input register block, the router FSM and the output FIFOs.
// master drives the source/FIFO status side (pkt_vld, data_in, parity_done, low_pkt_vld, fifo_full, fifo_empty, sft_rst);
// slave is the FSM side driving busy, the state strobes, write_en_reg, rst_int_reg, dest_sel, addr_err and wait_timeout.
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_vld;
  logic [ADDR_W-1:0] data_in;
  logic              parity_done;
  logic              low_pkt_vld;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] sft_rst;
  logic              busy;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_en_reg;
  logic              rst_int_reg;
  logic [NUM_CH-1:0] dest_sel;
  logic              addr_err;
  logic              wait_timeout;
  modport master (
    output pkt_vld, data_in, parity_done, low_pkt_vld, fifo_full, fifo_empty, sft_rst,
    input  busy, detect_addr, lfd_state, ld_state, laf_state, full_state, write_en_reg,
           rst_int_reg, dest_sel, addr_err, wait_timeout
  );
  modport slave (
    input  pkt_vld, data_in, parity_done, low_pkt_vld, fifo_full, fifo_empty, sft_rst,
    output busy, detect_addr, lfd_state, ld_state, laf_state, full_state, write_en_reg,
           rst_int_reg, dest_sel, addr_err, wait_timeout
  );
endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: 1xNUM_CH packet-router control FSM sequencing header/payload/parity into the selected output FIFO.
// Ports: clk, rst (async active-high), b (router_fsm_nch_if.slave) carrying source/FIFO status in, state strobes,
// write enable, one-hot dest_sel and addr_err/wait_timeout pulses out.
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input logic             clk,
  input logic             rst,
  router_fsm_nch_if.slave b
);
  typedef enum logic [3:0] {
    DECODE_ADDR        = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    CHECK_PARITY_ERROR = 4'd4,
    FIFO_FULL_STATE    = 4'd5,
    LOAD_AFTER_FULL    = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PKT           = 4'd8
  } state_t;
  state_t               ps, ns, nxt;
  logic [ADDR_W-1:0]    addr;
  logic [CNT_W-1:0]     cnt;
  logic [2**ADDR_W-1:0] empty_x, srst_x;
  logic [NUM_CH-1:0]    one;
  logic                 hdr_vld, tmo, srst, waiting;
  // Pad per-channel vectors to the full address space so any address indexes safely.
  always_comb begin
    empty_x = '0;
    empty_x[NUM_CH-1:0] = b.fifo_empty;
    srst_x = '0;
    srst_x[NUM_CH-1:0] = b.sft_rst;
  end
  assign one     = NUM_CH'(1);
  assign hdr_vld = 32'(b.data_in) < NUM_CH;
  assign tmo     = WAIT_TIMEOUT != 0 && cnt == CNT_W'(WAIT_TIMEOUT - 1);
  // Soft reset only matters while a channel is actually in use.
  assign srst    = ps != DECODE_ADDR && ps != DROP_PKT && srst_x[addr];
  always_comb begin
    ns = DECODE_ADDR;
    case (ps)
      DECODE_ADDR:        ns = !b.pkt_vld ? DECODE_ADDR : !hdr_vld ? DROP_PKT :
                               empty_x[b.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    ns = LOAD_DATA;
      LOAD_DATA:          ns = b.fifo_full ? FIFO_FULL_STATE : !b.pkt_vld ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        ns = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: ns = b.fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
      FIFO_FULL_STATE:    ns = b.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    ns = b.parity_done ? DECODE_ADDR : b.low_pkt_vld ? LOAD_PARITY : LOAD_DATA;
      WAIT_TILL_EMPTY:    ns = empty_x[addr] ? LOAD_FIRST_DATA : tmo ? DECODE_ADDR : WAIT_TILL_EMPTY;
      DROP_PKT:           ns = b.pkt_vld ? DROP_PKT : DECODE_ADDR;
      default:            ns = DECODE_ADDR;
    endcase
    nxt = srst ? DECODE_ADDR : ns;
  end
  // Counter only advances while remaining in WAIT_TILL_EMPTY, saturating at all-ones.
  assign waiting = ps == WAIT_TILL_EMPTY && nxt == WAIT_TILL_EMPTY;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps             <= DECODE_ADDR;
      addr           <= '0;
      cnt            <= '0;
      b.addr_err     <= 1'b0;
      b.wait_timeout <= 1'b0;
    end else begin
      ps             <= nxt;
      addr           <= ps == DECODE_ADDR && b.pkt_vld ? b.data_in : addr;
      cnt            <= waiting ? cnt + CNT_W'(cnt != '1) : '0;
      b.addr_err     <= ps == DECODE_ADDR && b.pkt_vld && !hdr_vld;
      b.wait_timeout <= ps == WAIT_TILL_EMPTY && !empty_x[addr] && tmo;
    end
  end
  assign b.detect_addr  = ps == DECODE_ADDR;
  assign b.lfd_state    = ps == LOAD_FIRST_DATA;
  assign b.ld_state     = ps == LOAD_DATA;
  assign b.laf_state    = ps == LOAD_AFTER_FULL;
  assign b.full_state   = ps == FIFO_FULL_STATE;
  assign b.rst_int_reg  = ps == CHECK_PARITY_ERROR;
  assign b.write_en_reg = ps inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
  assign b.busy         = ps inside {LOAD_FIRST_DATA, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE,
                                     LOAD_AFTER_FULL, WAIT_TILL_EMPTY, DROP_PKT};
  assign b.dest_sel     = ps == DECODE_ADDR || ps == DROP_PKT ? '0 : one << addr;
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: table-driven scoreboard bench for router_fsm_nch (default timeout instance plus an 8-cycle timeout instance).
module tb_router_fsm_nch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bi ();
  router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) ti ();
  router_fsm_nch dut (.clk(clk), .rst(rst), .b(bi));
  router_fsm_nch #(.WAIT_TIMEOUT(8)) dut8 (.clk(clk), .rst(rst), .b(ti));
  assign ti.pkt_vld     = bi.pkt_vld;
  assign ti.data_in     = bi.data_in;
  assign ti.parity_done = bi.parity_done;
  assign ti.low_pkt_vld = bi.low_pkt_vld;
  assign ti.fifo_full   = bi.fifo_full;
  assign ti.fifo_empty  = bi.fifo_empty;
  assign ti.sft_rst     = bi.sft_rst;
  typedef enum logic [3:0] {S_DA, S_LFD, S_LD, S_LP, S_CPE, S_FFS, S_LAF, S_WTE, S_DROP} st_t;
  typedef struct {
    bit t, rp, pv;
    logic [1:0] din;
    bit ff, lpv, pd;
    logic [2:0] fe, sr;
    st_t st;
    logic [2:0] ds;
    bit ae, wt;
  } vec_t;
  typedef struct {
    bit t;
    logic [12:0] v;
    int id;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int n = 0;
  int fails = 0;
  // {busy, detect_addr, lfd, ld, laf, full, write_en_reg, rst_int_reg}
  function automatic logic [7:0] flags(input st_t s);
    case (s)
      S_DA:    return 8'b0100_0000;
      S_LFD:   return 8'b1010_0000;
      S_LD:    return 8'b0001_0010;
      S_LP:    return 8'b1000_0010;
      S_CPE:   return 8'b1000_0001;
      S_FFS:   return 8'b1000_0100;
      S_LAF:   return 8'b1000_1010;
      default: return 8'b1000_0000;
    endcase
  endfunction
  function automatic logic [12:0] obs(input bit t);
    return t ? {ti.busy, ti.detect_addr, ti.lfd_state, ti.ld_state, ti.laf_state, ti.full_state,
                ti.write_en_reg, ti.rst_int_reg, ti.dest_sel, ti.addr_err, ti.wait_timeout}
             : {bi.busy, bi.detect_addr, bi.lfd_state, bi.ld_state, bi.laf_state, bi.full_state,
                bi.write_en_reg, bi.rst_int_reg, bi.dest_sel, bi.addr_err, bi.wait_timeout};
  endfunction
  function automatic void add(input st_t st, input logic [2:0] ds, input bit pv,
                              input logic [1:0] din = 0, input logic [2:0] fe = 3'b111,
                              input bit ff = 0, input bit lpv = 0, input bit pd = 0,
                              input logic [2:0] sr = 0, input bit ae = 0, input bit wt = 0,
                              input bit t = 0, input bit rp = 0);
    vec_t c;
    c.t = t; c.rp = rp; c.pv = pv; c.din = din; c.ff = ff; c.lpv = lpv; c.pd = pd;
    c.fe = fe; c.sr = sr; c.st = st; c.ds = ds; c.ae = ae; c.wt = wt;
    tbl.push_back(c);
  endfunction
  task automatic expect_now(input bit t, input st_t st, input logic [2:0] ds, input bit ae, input bit wt, input int id);
    exp_t e;
    e.t = t; e.v = {flags(st), ds, ae, wt}; e.id = id;
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    logic [12:0] a;
    e = sb.pop_front();
    a = obs(e.t);
    n++;
    if (a !== e.v) begin
      fails++;
      $display("FAIL vec%0d dut%0d outputs got %b want %b", e.id, e.t, a, e.v);
    end
  endtask
  task automatic drive(input bit pv, input logic [1:0] din, input bit ff, input bit lpv, input bit pd,
                       input logic [2:0] fe, input logic [2:0] sr);
    bi.pkt_vld = pv; bi.data_in = din; bi.fifo_full = ff; bi.low_pkt_vld = lpv;
    bi.parity_done = pd; bi.fifo_empty = fe; bi.sft_rst = sr;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 3'b111, 3'b000);
    // addr 1 normal packet, 4 payload cycles
    add(S_LFD, 3'b010, 1, 1);
    repeat (4) add(S_LD, 3'b010, 1, 1);
    add(S_LP, 3'b010, 0); add(S_CPE, 3'b010, 0); add(S_DA, 3'b000, 0);
    // addr 2 busy destination, drains after 10 wait cycles
    repeat (10) add(S_WTE, 3'b100, 1, 2, 3'b011);
    add(S_LFD, 3'b100, 1, 2, 3'b111);
    add(S_LD, 3'b100, 1); add(S_LP, 3'b100, 0); add(S_CPE, 3'b100, 0); add(S_DA, 3'b000, 0);
    // invalid address 3 dropped while pkt_vld held
    add(S_DROP, 3'b000, 1, 3, 3'b111, 0, 0, 0, 0, 1);
    repeat (4) add(S_DROP, 3'b000, 1, 3);
    add(S_DA, 3'b000, 0);
    // fifo_full stall for 3 cycles then resume with low_pkt_vld
    add(S_LFD, 3'b010, 1, 1); add(S_LD, 3'b010, 1, 1);
    add(S_FFS, 3'b010, 1, 1, 3'b111, 1);
    repeat (2) add(S_FFS, 3'b010, 0, 0, 3'b111, 1, 1);
    add(S_LAF, 3'b010, 0, 0, 3'b111, 0, 1);
    add(S_LP, 3'b010, 0, 0, 3'b111, 0, 1);
    add(S_CPE, 3'b010, 0); add(S_DA, 3'b000, 0);
    // soft reset on another channel ignored, on own channel aborts
    add(S_LFD, 3'b001, 1, 0); add(S_LD, 3'b001, 1, 0);
    add(S_LD, 3'b001, 1, 0, 3'b111, 0, 0, 0, 3'b100);
    add(S_DA, 3'b000, 1, 0, 3'b111, 0, 0, 0, 3'b001);
    add(S_DA, 3'b000, 0);
    // 8-cycle timeout instance: exactly 8 WAIT cycles then abort pulse
    add(S_WTE, 3'b001, 1, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (7) add(S_WTE, 3'b001, 0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1);
    add(S_DA, 3'b000, 0, 0, 3'b110, 0, 0, 0, 0, 0, 1, 1);
    add(S_DA, 3'b000, 0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1);
    // empty wins over timeout on the final wait cycle
    add(S_WTE, 3'b001, 1, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1);
    repeat (7) add(S_WTE, 3'b001, 0, 0, 3'b110, 0, 0, 0, 0, 0, 0, 1);
    add(S_LFD, 3'b001, 1, 0, 3'b111, 0, 0, 0, 0, 0, 0, 1);
    add(S_LD, 3'b001, 1, 0, 3'b111, 0, 0, 0, 0, 0, 0, 1);
    add(S_LP, 3'b001, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 1);
    add(S_CPE, 3'b001, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 1);
    add(S_DA, 3'b000, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 1);
    #12;
    expect_now(0, S_DA, 3'b000, 0, 0, -1); check();
    expect_now(1, S_DA, 3'b000, 0, 0, -2); check();
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t c;
      c = tbl[i];
      drive(c.pv, c.din, c.ff, c.lpv, c.pd, c.fe, c.sr);
      if (c.rp) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      expect_now(c.t, c.st, c.ds, c.ae, c.wt, i);
      @(posedge clk); #1;
      check();
    end
    // asynchronous reset mid-LOAD_DATA
    rst = 1'b1; #2; rst = 1'b0;
    drive(1, 0, 0, 0, 0, 3'b111, 3'b000);
    expect_now(0, S_LFD, 3'b001, 0, 0, 1000);
    @(posedge clk); #1; check();
    expect_now(0, S_LD, 3'b001, 0, 0, 1001);
    @(posedge clk); #1; check();
    #2 rst = 1'b1;
    #1;
    n++;
    if (!(bi.detect_addr === 1'b1 && bi.write_en_reg === 1'b0 && bi.dest_sel === 3'b000)) begin
      fails++;
      $display("FAIL async_rst got detect=%b we=%b dest=%b want 1 0 000", bi.detect_addr, bi.write_en_reg, bi.dest_sel);
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 3'b111, 3'b000);
    expect_now(0, S_DA, 3'b000, 0, 0, 1002);
    @(posedge clk); #1; check();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
